// File: rtl/ahbmtx_in_stage_if.sv
// Bus bundle between one AHB master, its matrix input stage and the output stages.
// The slave modport is the input stage's view; master is the driving side (master + matrix).
interface ahbmtx_in_stage_if #(
   parameter int unsigned ADDR_W = 32
);
   // Master-side address phase
   logic              HSELS;
   logic [ADDR_W-1:0] HADDRS;
   logic [1:0]        HTRANSS;
   logic              HWRITES;
   logic [2:0]        HSIZES;
   logic [2:0]        HBURSTS;
   logic [3:0]        HPROTS;
   logic              HMASTLOCKS;
   logic              HREADYS;
   logic              HREADYOUTS;
   logic              HRESPS;

   // Toward the output stages
   logic              req_port;
   logic [ADDR_W-1:0] HADDRI;
   logic [1:0]        HTRANSI;
   logic              HWRITEI;
   logic [2:0]        HSIZEI;
   logic [2:0]        HBURSTI;
   logic [3:0]        HPROTI;
   logic              HMASTLOCKI;

   // From the output stages and decoder
   logic              grant_in;
   logic              HREADYM;
   logic              data_active_in;
   logic              HREADYOUTM;
   logic              HRESPM;
   logic              dec_err_in;

   modport slave (
      input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
      output HREADYOUTS, HRESPS,
      output req_port, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI,
      input  grant_in, HREADYM, data_active_in, HREADYOUTM, HRESPM, dec_err_in
   );

   modport master (
      output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
      input  HREADYOUTS, HRESPS,
      input  req_port, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI,
      output grant_in, HREADYM, data_active_in, HREADYOUTM, HRESPM, dec_err_in
   );
endinterface

// File: rtl/ahbmtx_in_stage.sv
// AHB bus-matrix input stage: captures ungranted address phases and stalls the master.
// Define AHBMTX_INSTG_DECERR_EN to build the internal default slave for unmapped addresses.
module ahbmtx_in_stage #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   ahbmtx_in_stage_if.slave   io_bus
);

   logic              w_live_valid;
   logic              w_live_req;
   logic              w_accept;
   logic              w_load;
   logic              w_clear;
   logic              w_err_active;
   logic              w_err_ready;

   logic              r_hold_valid;
   logic [ADDR_W-1:0] r_haddr;
   logic [1:0]        r_htrans;
   logic              r_hwrite;
   logic [2:0]        r_hsize;
   logic [2:0]        r_hburst;
   logic [3:0]        r_hprot;
   logic              r_hmastlock;

   // IDLE and BUSY never request; a low HREADYS means the master is still stalled.
   assign w_live_valid = io_bus.HSELS & io_bus.HTRANSS[1] & io_bus.HREADYS;
   assign w_accept     = io_bus.grant_in & io_bus.HREADYM;

`ifdef AHBMTX_INSTG_DECERR_EN
   typedef enum logic [1:0] {
      StIdle,
      StErr1,
      StErr2
   } err_state_e;

   err_state_e r_err_state;
   err_state_e w_err_state_next;
   logic       w_dec_err;

   assign w_dec_err  = w_live_valid & io_bus.dec_err_in;
   assign w_live_req = w_live_valid & ~w_dec_err;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_err_state <= StIdle;
      end else begin
         r_err_state <= w_err_state_next;
      end
   end

   // Two-cycle ERROR response: first cycle stalls, second completes.
   always_comb begin
      w_err_state_next = r_err_state;
      w_err_active     = 1'b0;
      w_err_ready      = 1'b1;
      unique case (r_err_state)
         StIdle: begin
            if (w_dec_err) begin
               w_err_state_next = StErr1;
            end
         end
         StErr1: begin
            w_err_active     = 1'b1;
            w_err_ready      = 1'b0;
            w_err_state_next = StErr2;
         end
         StErr2: begin
            w_err_active     = 1'b1;
            w_err_ready      = 1'b1;
            w_err_state_next = w_dec_err ? StErr1 : StIdle;
         end
         default: begin
            w_err_state_next = StIdle;
         end
      endcase
   end
`else
   logic w_unused_dec_err;

   assign w_unused_dec_err = io_bus.dec_err_in;
   assign w_live_req       = w_live_valid;
   assign w_err_active     = 1'b0;
   assign w_err_ready      = 1'b1;
`endif

   assign w_load  = w_live_req & ~w_accept;
   assign w_clear = r_hold_valid & w_accept;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_hold_valid <= 1'b0;
         r_haddr      <= '0;
         r_htrans     <= 2'b00;
         r_hwrite     <= 1'b0;
         r_hsize      <= 3'b000;
         r_hburst     <= 3'b000;
         r_hprot      <= 4'b0000;
         r_hmastlock  <= 1'b0;
      end else if (w_clear) begin
         r_hold_valid <= 1'b0;
      end else if (w_load) begin
         r_hold_valid <= 1'b1;
         r_haddr      <= io_bus.HADDRS;
         r_htrans     <= io_bus.HTRANSS;
         r_hwrite     <= io_bus.HWRITES;
         r_hsize      <= io_bus.HSIZES;
         r_hburst     <= io_bus.HBURSTS;
         r_hprot      <= io_bus.HPROTS;
         r_hmastlock  <= io_bus.HMASTLOCKS;
      end
   end

   always_comb begin
      io_bus.HADDRI     = io_bus.HADDRS;
      io_bus.HTRANSI    = io_bus.HSELS ? io_bus.HTRANSS : 2'b00;
      io_bus.HWRITEI    = io_bus.HWRITES;
      io_bus.HSIZEI     = io_bus.HSIZES;
      io_bus.HBURSTI    = io_bus.HBURSTS;
      io_bus.HPROTI     = io_bus.HPROTS;
      io_bus.HMASTLOCKI = io_bus.HMASTLOCKS;
      if (r_hold_valid) begin
         io_bus.HADDRI     = r_haddr;
         io_bus.HTRANSI    = r_htrans;
         io_bus.HWRITEI    = r_hwrite;
         io_bus.HSIZEI     = r_hsize;
         io_bus.HBURSTI    = r_hburst;
         io_bus.HPROTI     = r_hprot;
         io_bus.HMASTLOCKI = r_hmastlock;
      end
   end

   assign io_bus.req_port = w_live_req | r_hold_valid;

   always_comb begin
      io_bus.HREADYOUTS = 1'b1;
      io_bus.HRESPS     = 1'b0;
      if (w_err_active) begin
         io_bus.HREADYOUTS = w_err_ready;
         io_bus.HRESPS     = 1'b1;
      end else if (io_bus.data_active_in) begin
         io_bus.HREADYOUTS = io_bus.HREADYOUTM;
         io_bus.HRESPS     = io_bus.HRESPM;
      end else if (r_hold_valid) begin
         io_bus.HREADYOUTS = 1'b0;
      end
   end

   // A stalled master cannot present a new transfer while one is held.
   a_no_load_while_held : assert property (
      @(posedge HCLK) disable iff (!HRESETn) !(r_hold_valid && w_load)
   );

endmodule
